// File: rtl/temp_uart_rx_if.sv
// Byte-side bundle between the UART receiver and the temperature packer.
// The receiver takes the master view: it samples the serial line and drives
// the byte, strobe, address and framing-error outputs. The consumer (packer
// or bench) takes the slave view.
interface temp_uart_rx_if;
  logic        rx;        // asynchronous UART line, idle high
  logic [7:0]  oData;     // last valid received byte
  logic        strob;     // byte-valid strobe, STROB_LEN cycles wide
  logic [10:0] oAddrRam;  // frame address of the byte on oData
  logic        frameErr;  // 1-cycle pulse on a bad stop bit

  modport master (
    input  rx,
    output oData,
    output strob,
    output oAddrRam,
    output frameErr
  );

  modport slave (
    output rx,
    input  oData,
    input  strob,
    input  oAddrRam,
    input  frameErr
  );
endinterface

// File: rtl/temp_uart_rx.sv
// 8N1 UART receiver feeding the temperature packer.
// Deserialises the sensor line into bytes, presents each byte with a
// multi-cycle strobe and a frame address, and re-aligns the address to 0
// whenever the line has idled long enough to mark a new sensor frame.
module temp_uart_rx #(
  parameter int CLKS_PER_BIT = 16,    // even, >= 4
  parameter int STROB_LEN    = 8,     // >= 6 and < 10*CLKS_PER_BIT
  parameter int FRAME_LEN    = 480,   // bytes per frame, <= 2048
  parameter int GAP_CLKS     = 2048   // idle-high cycles marking a frame boundary
) (
  input  logic          clk,
  input  logic          rst,
  temp_uart_rx_if.master bus
);

  localparam int BIT_W = $clog2(CLKS_PER_BIT);
  localparam int GAP_W = $clog2(GAP_CLKS + 1);
  localparam int STB_W = $clog2(STROB_LEN + 1);

  // Bit-time counter taps: middle of the start bit, and one full bit period
  // (which lands mid-bit for every later bit once aligned on the start bit).
  localparam logic [BIT_W-1:0] MID_START = BIT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_TICK = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CLKS - 1);
  localparam logic [STB_W-1:0] STB_LOAD  = STB_W'(STROB_LEN);
  localparam logic [10:0]      LAST_ADDR = 11'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,   // waiting for a falling edge on the line
    START,  // confirming the start bit at its midpoint
    DATA,   // sampling eight data bits, LSB first
    STOP,   // checking the stop bit
    HOLD    // line stuck low after a framing error (break)
  } state_t;

  state_t           state;
  logic             rxM;        // first synchroniser stage
  logic             rxS;        // synchronised line, used by all decisions
  logic [BIT_W-1:0] bitCnt;
  logic [2:0]       bitIdx;
  logic [7:0]       shReg;
  logic [10:0]      nextAddr;
  logic [GAP_W-1:0] gapCnt;
  logic [STB_W-1:0] strobCnt;

  logic [7:0]       oData_q;
  logic [10:0]      oAddrRam_q;
  logic             frameErr_q;

  assign bus.oData    = oData_q;
  assign bus.oAddrRam = oAddrRam_q;
  assign bus.frameErr = frameErr_q;
  // Decoded straight from the counter so an asynchronous reset drops the
  // strobe in the same instant it clears strobCnt.
  assign bus.strob    = (strobCnt != '0);

  // Two-flop synchroniser for the asynchronous line; resets to the idle level
  // so leaving reset never looks like a start bit.
  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the values from before the edge, as real hardware does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxM <= 1'b1;
      rxS <= 1'b1;
    end else begin
      rxM <= bus.rx;
      rxS <= rxM;
    end
  end

  // Receive FSM with strobe stretcher and idle-gap address re-alignment;
  // all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bitCnt     <= '0;
      bitIdx     <= '0;
      shReg      <= '0;
      nextAddr   <= '0;
      gapCnt     <= '0;
      strobCnt   <= '0;
      oData_q    <= '0;
      oAddrRam_q <= '0;
      frameErr_q <= 1'b0;
    end else begin
      // frameErr is a single-cycle pulse unless re-asserted below.
      frameErr_q <= 1'b0;

      // Strobe counts down to zero; a valid byte below reloads it, which
      // also covers a byte landing while the strobe is still high.
      if (strobCnt != '0) begin
        strobCnt <= strobCnt - STB_W'(1);
      end

      // Idle-gap timer: counts idle-high cycles, saturates at the boundary
      // and holds the next address at 0 until a byte arrives. Only IDLE
      // touches nextAddr here, STOP only touches it below, so they never
      // collide.
      if (!rxS) begin
        gapCnt <= '0;
      end else if (state == IDLE) begin
        if (gapCnt == GAP_LAST) begin
          nextAddr <= '0;
        end else begin
          gapCnt <= gapCnt + GAP_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (!rxS) begin
            bitCnt <= '0;
            state  <= START;
          end
        end

        START: begin
          if (bitCnt == MID_START) begin
            if (!rxS) begin
              bitCnt <= '0;
              bitIdx <= '0;
              state  <= DATA;
            end else begin
              // Line went back high before mid start bit: a glitch.
              state <= IDLE;
            end
          end else begin
            bitCnt <= bitCnt + BIT_W'(1);
          end
        end

        DATA: begin
          if (bitCnt == LAST_TICK) begin
            bitCnt <= '0;
            shReg  <= {rxS, shReg[7:1]};
            if (bitIdx == 3'd7) begin
              state <= STOP;
            end else begin
              bitIdx <= bitIdx + 3'd1;
            end
          end else begin
            bitCnt <= bitCnt + BIT_W'(1);
          end
        end

        STOP: begin
          if (bitCnt == LAST_TICK) begin
            bitCnt <= '0;
            if (rxS) begin
              oData_q    <= shReg;
              oAddrRam_q <= nextAddr;
              nextAddr   <= (nextAddr == LAST_ADDR) ? 11'd0 : nextAddr + 11'd1;
              strobCnt   <= STB_LOAD;
              state      <= IDLE;
            end else begin
              // Bad stop bit: drop the byte, keep all visible state.
              frameErr_q <= 1'b1;
              state      <= HOLD;
            end
          end else begin
            bitCnt <= bitCnt + BIT_W'(1);
          end
        end

        HOLD: begin
          // A held-low line (break) stays here and never yields bytes.
          if (rxS) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/temp_uart_rx.md
# temp_uart_rx

Serial receiver in front of the temperature packer. It deserialises the temperature sensor's 8N1 UART line into bytes and presents each byte on `oData`. Each byte comes with a multi-cycle `strob` pulse and a frame address `oAddrRam`. These three outputs drive the packer's `iData`, `strob` and `iAddrRam` inputs directly. An idle-gap timer re-aligns the address counter to 0 at the start of every sensor frame.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clk cycles per UART bit. Must be even and ≥ 4.
- `STROB_LEN`, default 8: `strob` high time in cycles. Must be ≥ 6 and < 10·`CLKS_PER_BIT`.
- `FRAME_LEN`, default 480: bytes per frame. Addresses run 0..`FRAME_LEN`-1.
- `GAP_CLKS`, default 2048: rx idle-high cycles that mark a frame boundary.

Ports (clock and reset first):
- `clk`, in, 1: single system clock. All logic is on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `rx`, in, 1: asynchronous UART line, idle high.
- `oData`, out, 8: last valid received byte.
- `strob`, out, 1: byte-valid strobe, high for `STROB_LEN` cycles.
- `oAddrRam`, out, 11: frame address of the byte on `oData`.
- `frameErr`, out, 1: 1-cycle pulse when a stop bit is bad.

## Operation
- Input sync: `rx` passes through a 2-flop synchroniser; both flops reset to 1. All decisions use the synchronised bit `rxS`.
- Bit-time counter: `bitCnt`, width ceil(log2(`CLKS_PER_BIT`)).
- States: IDLE, START, DATA, STOP, HOLD.
- IDLE:
  - On `rxS`=0, clear `bitCnt` and go to START.
- START:
  - At `bitCnt` = `CLKS_PER_BIT`/2-1 (mid start bit), sample `rxS`.
  - If 0: clear `bitCnt`, clear `bitIdx`, go to DATA.
  - If 1: treat as a glitch and return to IDLE with no output.
- DATA:
  - Every `CLKS_PER_BIT` cycles (mid-bit), shift `rxS` into `shReg`, LSB first.
  - After the 8th sample, go to STOP.
- STOP, at mid stop bit:
  - `rxS`=1 (valid byte):
    - `oData`←`shReg`.
    - `oAddrRam`←`nextAddr`.
    - `nextAddr`← 0 if `nextAddr` = `FRAME_LEN`-1, else `nextAddr`+1.
    - Load `strobCnt`←`STROB_LEN` and go to IDLE.
  - `rxS`=0 (frame error): pulse `frameErr`, discard the byte, leave `oData`/`oAddrRam`/`nextAddr` unchanged, go to HOLD.
- HOLD:
  - Wait for `rxS`=1, then go to IDLE.
  - A continuous low (break) never produces bytes.
- Strobe:
  - `strob` = (`strobCnt` ≠ 0). `strobCnt` decrements to 0.
  - If a new valid byte lands while `strob` is high, `strobCnt` reloads and `strob` stays high. This is unreachable under the parameter rules but must be handled.
- Gap timer:
  - `gapCnt` counts cycles with `rxS`=1 in IDLE and clears on any `rxS`=0.
  - On reaching `GAP_CLKS`-1: `nextAddr`←0, and `gapCnt` saturates.
  - `oAddrRam` itself is unchanged until the next byte.
- Arithmetic: `nextAddr` and `oAddrRam` are 11 bits. `FRAME_LEN` ≤ 2048.

## Timing
- Reset values:
  - `oData`=0, `strob`=0, `oAddrRam`=0, `frameErr`=0.
  - state=IDLE; `nextAddr`, `gapCnt`, `strobCnt`, `shReg` = 0.
  - Synchroniser flops = 1.
- Reset mid-byte aborts the byte and drops `strob` immediately (asynchronously).
- Latency from the `rx` falling edge (start) to `strob` rising: 2 (sync) + 9.5·`CLKS_PER_BIT` + 1 cycles. That is 155 cycles at default parameters.
- Output timing:
  - `oData` and `oAddrRam` change on the same edge that `strob` rises.
  - They are stable for at least the whole `strob` pulse and until the next valid byte.
- `frameErr` rises 1 cycle after the stop-bit mid-sample and is exactly 1 cycle wide.
- A start edge during `strob` high is accepted normally. Reception and strobe are independent.
- Gap: the address realigns `GAP_CLKS` cycles after `rxS` goes high and stays high in IDLE.

## Test plan
All scenarios use default parameters.
- Reset, then one byte 0xA5 sent at 16 clk/bit:
  - Expect `oData`=0xA5 and `oAddrRam`=0.
  - Expect `strob` high exactly 8 cycles, rising 155 cycles after the start edge.
  - Expect `frameErr` never asserted.
- 481 back-to-back bytes (values i mod 256):
  - Expect `oAddrRam` to step 0..479 then wrap to 0 on byte 481.
  - Expect `oData` to match each byte.
  - Expect one `strob` per byte.
- Send 10 bytes, idle 2048+ cycles, send 0x3C:
  - Expect `oAddrRam`=0 for 0x3C.
  - With only a 1000-cycle idle, expect `oAddrRam`=10 instead.
- Byte 0x55 with the stop bit forced low:
  - Expect a 1-cycle `frameErr`, no `strob`, and `oData`/`oAddrRam` unchanged.
  - Release the line, then send 0x12: expect it received at the next address.
- 4-cycle low glitch on `rx`:
  - Expect return to IDLE with no `strob` and no `frameErr`.
  - A following byte 0x81 must be received correctly.
- Assert `rst` mid-DATA, then while `strob` is high:
  - Expect all outputs at reset values immediately.
  - A full byte sent after release must be received at `oAddrRam`=0.
